mc_ctrl: RTL

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle combinational control with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memory and drives the datapath selects, including the immediate-format select consumed by the immediate generator. It sits between the instruction register and the datapath muxes, PC register and register file.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_ctrl_decode.sv | 74 +++++++
 rtl/mc_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle RV32I control sequencer.
// Holds the opcode values, FSM state codes, immediate-format selects (also
// consumed by the immediate generator), datapath mux select codes and the
// decoded-control payload passed from mc_ctrl_decode to mc_ctrl.
package mc_ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    // RV32I base opcodes (ir[6:0])
    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_SBTYPE = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Immediate-format selects
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // PC next-value select
    localparam logic [1:0] PC_SEL_PC4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_ALU = 2'd2;

    // Register-file write-back select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // ALU operand selects
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
    localparam logic [1:0] ALU_OP_CMP   = 2'd2;

    // Per-opcode control bundle
    typedef struct packed {
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode decoder for mc_ctrl.
// Ports:
//   opcode - ir[6:0]
//   dec    - decoded control bundle (imm/alu/wb selects, class flags, legal)
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    // Opcode -> control bundle; unknown opcodes leave legal=0
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_RTYPE: begin
                dec.alu_op = ALU_OP_FUNCT;
                dec.legal  = 1'b1;
            end
            OPC_ITYPE: begin
                dec.imm_sel   = IMM_I;
                dec.alu_src_b = ALU_B_IMM;
                dec.alu_op    = ALU_OP_FUNCT;
                dec.legal     = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm_sel   = IMM_I;
                dec.alu_src_b = ALU_B_IMM;
                dec.wb_sel    = WB_SEL_MEM;
                dec.is_load   = 1'b1;
                dec.legal     = 1'b1;
            end
            OPC_STORE: begin
                dec.imm_sel   = IMM_S;
                dec.alu_src_b = ALU_B_IMM;
                dec.is_store  = 1'b1;
                dec.legal     = 1'b1;
            end
            OPC_SBTYPE: begin
                dec.imm_sel   = IMM_B;
                dec.alu_op    = ALU_OP_CMP;
                dec.is_branch = 1'b1;
                dec.legal     = 1'b1;
            end
            OPC_JAL: begin
                dec.imm_sel = IMM_J;
                dec.wb_sel  = WB_SEL_PC4;
                dec.is_jump = 1'b1;
                dec.legal   = 1'b1;
            end
            OPC_JALR: begin
                dec.imm_sel   = IMM_I;
                dec.alu_src_b = ALU_B_IMM;
                dec.wb_sel    = WB_SEL_PC4;
                dec.is_jump   = 1'b1;
                dec.legal     = 1'b1;
            end
            OPC_LUI: begin
                dec.imm_sel   = IMM_U;
                dec.alu_src_a = ALU_A_ZERO;
                dec.alu_src_b = ALU_B_IMM;
                dec.legal     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm_sel   = IMM_U;
                dec.alu_src_a = ALU_A_PC;
                dec.alu_src_b = ALU_B_IMM;
                dec.legal     = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory and drives the datapath selects.
// Ports:
//   clk, rst (sync, active-high)
//   ir, imem_ready, dmem_ready, branch_taken           - inputs
//   imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we   - strobes
//   pc_sel, wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel - datapath selects
//   illegal, state                                     - status / debug
//   cycle_cnt, instret_cnt                             - perf counters
// Build option: define CTRL_PERF_EN to enable the perf counters; otherwise
// both counter outputs are tied to zero.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  ir,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state_q;
    dec_t   dec;

    // Only the opcode field steers control
    logic unused_ir;
    assign unused_ir = ^ir[XLEN-1:OPC_W];

    mc_ctrl_decode u_decode (
        .opcode (ir[OPC_W-1:0]),
        .dec    (dec)
    );

    // State register; unused codes fall back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (imem_ready) state_q <= S_DECODE;
                S_DECODE: state_q <= dec.legal ? S_EXEC : S_HALT;
                S_EXEC: begin
                    if (dec.is_branch)                    state_q <= S_FETCH;
                    else if (dec.is_load || dec.is_store) state_q <= S_MEM;
                    else                                  state_q <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) state_q <= dec.is_load ? S_WB : S_FETCH;
                end
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign state = 3'(state_q);

    // Output decode from state and opcode; memory handshake and branch
    // outcome qualify the strobes in the same cycle. Reset forces all quiet.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_RS2;
        alu_op    = ALU_OP_ADD;
        imm_sel   = IMM_I;
        illegal   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    alu_src_a = dec.alu_src_a;
                    alu_src_b = dec.alu_src_b;
                    alu_op    = dec.alu_op;
                    if (dec.is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec.is_store;
                    // Stores retire here; loads continue to WB
                    if (dmem_ready && dec.is_store) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_PC4;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    wb_sel = dec.wb_sel;
                    // JAL targets pc+imm, JALR targets the ALU result
                    if (dec.is_jump)
                        pc_sel = (dec.imm_sel == IMM_J) ? PC_SEL_IMM : PC_SEL_ALU;
                end
                S_HALT:  illegal = 1'b1;
                default: ;
            endcase
            if (state_q != S_FETCH) imm_sel = dec.imm_sel;
        end
    end

`ifdef CTRL_PERF_EN
    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_we) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
